// File: rtl/iob_eth_rx_pack_pkg.sv
// Shared types and defaults for the Ethernet RX byte-to-word packer.
package iob_eth_rx_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam int BUF_ADDR_W_DEF = 9;
  localparam int LEN_W_DEF      = 11;
  localparam int MAX_BYTES_DEF  = 2047;

  // Byte enables covering lanes 0..lane of a (possibly partial) word.
  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_strb = 4'h1;
      2'd1:    lane_strb = 4'h3;
      2'd2:    lane_strb = 4'h7;
      default: lane_strb = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/iob_eth_rx_pack_if.sv
// Bundle of the MAC RX stream, frame-buffer write port and DMA handshake.
interface iob_eth_rx_pack_if #(
  parameter int BUF_ADDR_W = 9,
  parameter int LEN_W      = 11
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_sof;
  logic                  rx_eof;
  logic                  rx_err;
  logic [31:0]           buf_wdata;
  logic [BUF_ADDR_W-1:0] buf_waddr;
  logic                  buf_wr;
  logic [3:0]            buf_wstrb;
  logic [LEN_W-1:0]      frame_len;
  logic                  frame_ready;
  logic                  frame_ack;
  logic                  frame_drop;
  logic [15:0]           drop_cnt;

  // Packer side.
  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, frame_ack,
    output buf_wdata, buf_waddr, buf_wr, buf_wstrb,
           frame_len, frame_ready, frame_drop, drop_cnt
  );

  // MAC / DMA / buffer side.
  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err, frame_ack,
    input  buf_wdata, buf_waddr, buf_wr, buf_wstrb,
           frame_len, frame_ready, frame_drop, drop_cnt
  );
endinterface

// File: rtl/iob_eth_rx_pack_lane.sv
// Byte-to-word lane register: merges accepted bytes little-endian and
// issues one registered buffer write per full word or at end of frame.
module iob_eth_rx_pack_lane
  import iob_eth_rx_pack_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              take,
  input  logic [1:0]        lane,
  input  logic [7:0]        data,
  input  logic              last,
  input  logic [ADDR_W-1:0] waddr_in,
  output logic [31:0]       wdata,
  output logic [ADDR_W-1:0] waddr,
  output logic              wr,
  output logic [3:0]        wstrb
);

  logic [31:0] acc;
  logic [31:0] word_next;
  logic        flush;

  // Lane 0 starts a fresh word, so stale upper lanes never leak into a partial write.
  always_comb begin
    word_next = (lane == 2'd0) ? 32'h0 : acc;
    word_next = word_next | (32'(data) << {lane, 3'b000});
    flush     = (lane == 2'd3) || last;
  end

  // Accumulate bytes and register the outgoing write one cycle after the completing byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= 32'h0;
      wdata <= 32'h0;
      waddr <= '0;
      wr    <= 1'b0;
      wstrb <= 4'h0;
    end else begin
      wr <= take && flush;
      if (take) begin
        acc <= word_next;
        if (flush) begin
          wdata <= word_next;
          waddr <= waddr_in;
          wstrb <= lane_strb(lane);
        end
      end
    end
  end

endmodule

// File: rtl/iob_eth_rx_pack.sv
// Ethernet RX packer: frame FSM, byte counter and drop accounting in front
// of the lane register that writes the DMA frame buffer.
module iob_eth_rx_pack
  import iob_eth_rx_pack_pkg::*;
#(
  parameter int BUF_ADDR_W = BUF_ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int MAX_BYTES  = MAX_BYTES_DEF
) (
  input logic              clk,
  input logic              rst,
  iob_eth_rx_pack_if.slave bus
);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] idx;
  logic             start;
  logic             in_frame;
  logic             bad;
  logic             take;
  logic             drop_ev;

  // Classify the current byte; an sof always restarts the byte index at 0.
  always_comb begin
    start    = bus.rx_valid && bus.rx_sof;
    in_frame = start ? (state == ST_IDLE || state == ST_RECV)
                     : (state == ST_RECV && bus.rx_valid);
    idx      = (state == ST_RECV && !start) ? cnt : '0;
    bad      = bus.rx_err || (idx == LEN_W'(MAX_BYTES));
    take     = in_frame && !bad;
    // Error/overflow, a restart inside RECV, or a new frame while the buffer is held.
    drop_ev  = (in_frame && bad) ||
               (start && (state == ST_RECV || state == ST_HOLD));
  end

  // Frame FSM with length, ready and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bus.frame_len   <= '0;
      bus.frame_ready <= 1'b0;
      bus.frame_drop  <= 1'b0;
      bus.drop_cnt    <= 16'h0;
    end else begin
      bus.frame_drop <= drop_ev;
      if (drop_ev && bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 16'd1;
      case (state)
        ST_IDLE, ST_RECV: begin
          if (in_frame) begin
            if (bad) begin
              // A bad last byte already closes the frame, nothing left to skip.
              state <= bus.rx_eof ? ST_IDLE : ST_DROP;
              cnt   <= '0;
            end else if (bus.rx_eof) begin
              state           <= ST_HOLD;
              bus.frame_len   <= idx + 1'b1;
              bus.frame_ready <= 1'b1;
              cnt             <= '0;
            end else begin
              state <= ST_RECV;
              cnt   <= idx + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Bytes of frames arriving here are never written; only the ack frees the buffer.
          if (bus.frame_ack) begin
            state           <= ST_IDLE;
            bus.frame_ready <= 1'b0;
          end
        end
        default: begin
          if (bus.rx_valid && bus.rx_eof) state <= ST_IDLE;
        end
      endcase
    end
  end

  iob_eth_rx_pack_lane #(
    .ADDR_W(BUF_ADDR_W)
  ) u_lane (
    .clk      (clk),
    .rst      (rst),
    .take     (take),
    .lane     (idx[1:0]),
    .data     (bus.rx_data),
    .last     (bus.rx_eof),
    .waddr_in (BUF_ADDR_W'(idx >> 2)),
    .wdata    (bus.buf_wdata),
    .waddr    (bus.buf_waddr),
    .wr       (bus.buf_wr),
    .wstrb    (bus.buf_wstrb)
  );

endmodule

// File: tb/tb_iob_eth_rx_pack.sv
// Bench for iob_eth_rx_pack: frame-level vector table, hand-written corner
// sequences and randomized frames against a byte-list reference model.
module tb_iob_eth_rx_pack;

  localparam int AW = 9;
  localparam int LW = 11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } wr_t;

  typedef struct {
    int            len;
    int            err_pos;
    logic          exp_ready;
    int            exp_len;
    int            exp_writes;
    logic [AW-1:0] exp_last_addr;
    logic [3:0]    exp_last_strb;
    int            exp_drop_inc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_drops = 0;
  int   drop_pulses = 0;
  wr_t  got[$];

  iob_eth_rx_pack_if #(.BUF_ADDR_W(AW), .LEN_W(LW)) bus ();

  iob_eth_rx_pack #(.BUF_ADDR_W(AW), .LEN_W(LW), .MAX_BYTES(2047)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record buffer writes and drop pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.buf_wr === 1'b1) got.push_back(wr_t'{bus.buf_waddr, bus.buf_wdata, bus.buf_wstrb});
    if (bus.frame_drop === 1'b1) drop_pulses++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof,
                           input logic err, input logic ack);
    bus.rx_valid  = 1'b1;
    bus.rx_data   = d;
    bus.rx_sof    = sof;
    bus.rx_eof    = eof;
    bus.rx_err    = err;
    bus.frame_ack = ack;
    @(posedge clk); #1;
    bus.rx_valid  = 1'b0;
    bus.rx_sof    = 1'b0;
    bus.rx_eof    = 1'b0;
    bus.rx_err    = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Bytes are base+i; eof on byte len-1 unless no_eof; optional err and ack positions.
  task automatic send_frame(input int len, input logic [7:0] base, input int err_pos,
                            input int ack_at, input int max_gap, input bit no_eof);
    for (int i = 0; i < len; i++) begin
      send_byte(8'(base + i), i == 0, (i == len - 1) && !no_eof, i == err_pos, i == ack_at);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    idle(2);
  endtask

  task automatic do_ack(input string name);
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    check({name, "_ready_after_ack"}, 64'(bus.frame_ready), 64'd0);
  endtask

  // Reference: a frame is its byte list cut into 4-byte little-endian words.
  task automatic check_writes(input string name, input int len, input logic [7:0] base);
    int  nw;
    wr_t e;
    nw = (len + 3) / 4;
    check({name, "_wr_count"}, 64'(got.size()), 64'(nw));
    for (int w = 0; w < nw && w < got.size(); w++) begin
      int errs_before;
      e = '0;
      e.addr = AW'(w);
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < len) begin
          e.data[8*b +: 8] = 8'(base + 4 * w + b);
          e.strb[b] = 1'b1;
        end
      end
      errs_before = errors;
      check($sformatf("%s_word%0d", name, w), 64'(got[w]), 64'(e));
      if (errors != errs_before) break;
    end
  endtask

  vec_t tbl[8];

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h0;
    bus.rx_sof    = 1'b0;
    bus.rx_eof    = 1'b0;
    bus.rx_err    = 1'b0;
    bus.frame_ack = 1'b0;

    tbl[0] = '{64,   -1, 1'b1, 64,   16,  9'd15,  4'hF, 0};
    tbl[1] = '{61,   -1, 1'b1, 61,   16,  9'd15,  4'h1, 0};
    tbl[2] = '{1,    -1, 1'b1, 1,    1,   9'd0,   4'h1, 0};
    tbl[3] = '{20,    9, 1'b0, 0,    0,   9'd0,   4'h0, 1};
    tbl[4] = '{7,    -1, 1'b1, 7,    2,   9'd1,   4'h7, 0};
    tbl[5] = '{2047, -1, 1'b1, 2047, 512, 9'd511, 4'h7, 0};
    tbl[6] = '{2048, -1, 1'b0, 0,    0,   9'd0,   4'h0, 1};
    tbl[7] = '{8,    -1, 1'b1, 8,    2,   9'd1,   4'hF, 0};

    // Reset state
    idle(3);
    check("rst_ready", 64'(bus.frame_ready), 64'd0);
    check("rst_wr", 64'(bus.buf_wr), 64'd0);
    check("rst_len", 64'(bus.frame_len), 64'd0);
    check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    rst = 1'b1;
    idle(2);

    // Table of whole frames
    for (int i = 0; i < 8; i++) begin
      logic [7:0] base;
      string      nm;
      base = 8'(i * 37);
      nm   = $sformatf("vec%0d", i);
      got.delete();
      send_frame(tbl[i].len, base, tbl[i].err_pos, -1, 0, 1'b0);
      exp_drops += tbl[i].exp_drop_inc;
      check({nm, "_ready"}, 64'(bus.frame_ready), 64'(tbl[i].exp_ready));
      check({nm, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(exp_drops));
      if (tbl[i].exp_ready) begin
        check({nm, "_len"}, 64'(bus.frame_len), 64'(tbl[i].exp_len));
        check({nm, "_nwr"}, 64'(got.size()), 64'(tbl[i].exp_writes));
        if (got.size() > 0) begin
          check({nm, "_last_addr"}, 64'(got[$].addr), 64'(tbl[i].exp_last_addr));
          check({nm, "_last_strb"}, 64'(got[$].strb), 64'(tbl[i].exp_last_strb));
          if (i == 0) check({nm, "_word0"}, 64'(got[0].data), 64'h03020100);
        end
        check_writes(nm, tbl[i].len, base);
        do_ack(nm);
      end
    end

    // Second sof while held, then sof coincident with ack: both dropped
    got.delete();
    send_frame(8, 8'h80, -1, -1, 0, 1'b0);
    check("hold_a_ready", 64'(bus.frame_ready), 64'd1);
    got.delete();
    send_frame(6, 8'h90, -1, -1, 0, 1'b0);
    exp_drops++;
    check("hold_b_nowr", 64'(got.size()), 64'd0);
    check("hold_b_ready", 64'(bus.frame_ready), 64'd1);
    check("hold_b_len", 64'(bus.frame_len), 64'd8);
    send_frame(5, 8'hA0, -1, 0, 0, 1'b0);
    exp_drops++;
    check("hold_c_nowr", 64'(got.size()), 64'd0);
    check("hold_c_ready", 64'(bus.frame_ready), 64'd0);
    check("hold_c_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drops));

    // sof restart inside RECV: old frame dropped, new one accepted from addr 0
    send_frame(5, 8'h10, -1, -1, 0, 1'b1);
    got.delete();
    send_frame(6, 8'h20, -1, -1, 0, 1'b0);
    exp_drops++;
    check("restart_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drops));
    check("restart_ready", 64'(bus.frame_ready), 64'd1);
    check("restart_len", 64'(bus.frame_len), 64'd6);
    check_writes("restart", 6, 8'h20);
    do_ack("restart");

    // Stray eof in IDLE is ignored; ack during RECV is ignored
    got.delete();
    send_byte(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("stray_eof_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drops));
    check("stray_eof_nowr", 64'(got.size()), 64'd0);
    send_frame(12, 8'h40, -1, 5, 0, 1'b0);
    check("ack_recv_ready", 64'(bus.frame_ready), 64'd1);
    check("ack_recv_len", 64'(bus.frame_len), 64'd12);
    check_writes("ack_recv", 12, 8'h40);
    do_ack("ack_recv");

    // Randomized frames with gaps, errors and frames arriving while held
    for (int r = 0; r < 40; r++) begin
      int         len;
      int         kind;
      logic [7:0] base;
      string      nm;
      len  = $urandom_range(1, 100);
      kind = $urandom_range(0, 4);
      base = 8'($urandom);
      nm   = $sformatf("rnd%0d", r);
      got.delete();
      if (kind == 0) begin
        send_frame(len, base, $urandom_range(0, len - 1), -1, 2, 1'b0);
        exp_drops++;
        check({nm, "_ready"}, 64'(bus.frame_ready), 64'd0);
      end else begin
        send_frame(len, base, -1, -1, 2, 1'b0);
        check({nm, "_ready"}, 64'(bus.frame_ready), 64'd1);
        check({nm, "_len"}, 64'(bus.frame_len), 64'(len));
        check_writes(nm, len, base);
        if (kind == 1) begin
          got.delete();
          send_frame($urandom_range(1, 20), 8'($urandom), -1, -1, 1, 1'b0);
          exp_drops++;
          check({nm, "_held_nowr"}, 64'(got.size()), 64'd0);
          check({nm, "_held_ready"}, 64'(bus.frame_ready), 64'd1);
        end
        do_ack(nm);
      end
      check({nm, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(exp_drops));
    end
    check("drop_pulses", 64'(drop_pulses), 64'(exp_drops));

    // Asynchronous reset in the middle of a frame
    send_frame(40, 8'h00, -1, -1, 0, 1'b0);
    do_ack("pre_rst");
    send_frame(30, 8'h33, -1, -1, 0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", 64'(bus.frame_ready), 64'd0);
    check("arst_len", 64'(bus.frame_len), 64'd0);
    check("arst_wdata", 64'(bus.buf_wdata), 64'd0);
    check("arst_wstrb", 64'(bus.buf_wstrb), 64'd0);
    check("arst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    idle(2);
    rst = 1'b1;
    exp_drops = 0;
    idle(1);
    got.delete();
    send_frame(8, 8'hC0, -1, -1, 0, 1'b0);
    check("post_rst_ready", 64'(bus.frame_ready), 64'd1);
    check("post_rst_len", 64'(bus.frame_len), 64'd8);
    check("post_rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    check_writes("post_rst", 8, 8'hC0);
    do_ack("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
